// File: rtl/static_control_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : static_control_bank_if
// Purpose  : Host-side bus for the static control bank: wire-in data, the
//            three trigger-in pulses, readback select and the live outputs.
// Revision : 1.0  initial release
// ============================================================================
interface static_control_bank_if #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4,
  parameter int ADDR_W = 2
);
  logic [WIDTH-1:0]     din;
  logic [ADDR_W-1:0]    addr;
  logic                 stage_trig;
  logic                 apply_trig;
  logic                 clear_trig;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_shadow;
  logic [WIDTH-1:0]     rd_data;
  logic [NCH*WIDTH-1:0] dout;
  logic [NCH-1:0]       dirty;
  logic                 applied;
  logic [15:0]          apply_cnt;
  logic                 addr_err;

  // Host side: drives data, address and triggers, observes the bank.
  modport master (
    output din, addr, stage_trig, apply_trig, clear_trig, rd_addr, rd_shadow,
    input  rd_data, dout, dirty, applied, apply_cnt, addr_err
  );

  // Bank side.
  modport slave (
    input  din, addr, stage_trig, apply_trig, clear_trig, rd_addr, rd_shadow,
    output rd_data, dout, dirty, applied, apply_cnt, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/static_control_bank.sv
`default_nettype none
// ============================================================================
// Module   : static_control_bank
// Purpose  : NCH x WIDTH static control words. Host writes land in a shadow
//            bank; an apply trigger commits every dirty word to the live
//            outputs on one clock edge. Optional auto-apply latches through.
// Revision : 1.0  initial release
// ============================================================================
module static_control_bank #(
  parameter int               WIDTH      = 16,
  parameter int               NCH        = 4,
  parameter int               ADDR_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               AUTO_APPLY = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  static_control_bank_if.slave  bus
);

  // NCH widened by one bit so NCH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NCH_W = (ADDR_W + 1)'(NCH);

  // Trigger history flops (zero after reset so a held trigger acts once).
  logic stage_trig_q, apply_trig_q, clear_trig_q;

  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] live_q   [NCH];
  logic [WIDTH-1:0] live_d   [NCH];
  logic [NCH-1:0]   dirty_q,     dirty_d;
  logic             applied_q,   applied_d;
  logic [15:0]      apply_cnt_q, apply_cnt_d;
  logic             addr_err_q,  addr_err_d;
  logic [WIDTH-1:0] rd_data_q,   rd_data_d;

  logic stage_edge, apply_edge, clear_edge;
  logic stage_ok, rd_ok;

  assign stage_edge = bus.stage_trig & ~stage_trig_q;
  assign apply_edge = bus.apply_trig & ~apply_trig_q;
  assign clear_edge = bus.clear_trig & ~clear_trig_q;
  assign stage_ok   = ({1'b0, bus.addr}    < NCH_W);
  assign rd_ok      = ({1'b0, bus.rd_addr} < NCH_W);

  // Next-state: clear dominates; apply commits pre-write shadow, then stage writes.
  always_comb begin
    shadow_d    = shadow_q;
    live_d      = live_q;
    dirty_d     = dirty_q;
    applied_d   = 1'b0;
    apply_cnt_d = apply_cnt_q;
    addr_err_d  = addr_err_q;
    if (clear_edge) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_d[i] = RESET_VAL;
        live_d[i]   = RESET_VAL;
      end
      dirty_d    = '0;
      addr_err_d = 1'b0;
    end else begin
      if (apply_edge) begin
        for (int i = 0; i < NCH; i++) begin
          if (dirty_q[i]) live_d[i] = shadow_q[i];
        end
        dirty_d     = '0;
        applied_d   = 1'b1;
        apply_cnt_d = apply_cnt_d + 16'd1;
      end
      if (stage_edge) begin
        if (stage_ok) begin
          shadow_d[bus.addr] = bus.din;
          if (AUTO_APPLY) begin
            // Latch-through: the word goes live now and never becomes dirty.
            live_d[bus.addr]  = bus.din;
            dirty_d[bus.addr] = 1'b0;
            applied_d         = 1'b1;
            apply_cnt_d       = apply_cnt_d + 16'd1;
          end else begin
            dirty_d[bus.addr] = 1'b1;
          end
        end else begin
          addr_err_d = 1'b1;
        end
      end
    end
  end

  // Readback samples the banks as they stand before this edge's updates.
  always_comb begin
    rd_data_d = '0;
    if (rd_ok) begin
      rd_data_d = bus.rd_shadow ? shadow_q[bus.rd_addr] : live_q[bus.rd_addr];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= RESET_VAL;
        live_q[i]   <= RESET_VAL;
      end
      dirty_q      <= '0;
      applied_q    <= 1'b0;
      apply_cnt_q  <= 16'd0;
      addr_err_q   <= 1'b0;
      rd_data_q    <= '0;
      stage_trig_q <= 1'b0;
      apply_trig_q <= 1'b0;
      clear_trig_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      live_q       <= live_d;
      dirty_q      <= dirty_d;
      applied_q    <= applied_d;
      apply_cnt_q  <= apply_cnt_d;
      addr_err_q   <= addr_err_d;
      rd_data_q    <= rd_data_d;
      stage_trig_q <= bus.stage_trig;
      apply_trig_q <= bus.apply_trig;
      clear_trig_q <= bus.clear_trig;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_dout
    assign bus.dout[g*WIDTH +: WIDTH] = live_q[g];
  end

  assign bus.dirty     = dirty_q;
  assign bus.applied   = applied_q;
  assign bus.apply_cnt = apply_cnt_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_static_control_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_static_control_bank
// Purpose  : Directed bench for static_control_bank: three instances cover
//            the default bank, a 3-channel bank and an auto-apply bank.
// Revision : 1.0  initial release
// ============================================================================
module tb_static_control_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  static_control_bank_if #(.WIDTH(16), .NCH(4), .ADDR_W(2)) if_a ();
  static_control_bank_if #(.WIDTH(16), .NCH(3), .ADDR_W(2)) if_b ();
  static_control_bank_if #(.WIDTH(16), .NCH(4), .ADDR_W(2)) if_c ();

  static_control_bank #(.WIDTH(16), .NCH(4), .ADDR_W(2), .RESET_VAL(16'h00A5), .AUTO_APPLY(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  static_control_bank #(.WIDTH(16), .NCH(3), .ADDR_W(2), .RESET_VAL(16'h0055), .AUTO_APPLY(1'b0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  static_control_bank #(.WIDTH(16), .NCH(4), .ADDR_W(2), .RESET_VAL(16'h0000), .AUTO_APPLY(1'b1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  // Expected value goes in when the stimulus is set up.
  task automatic expect_v(input logic [63:0] v);
    sb.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {if_a.din, if_a.addr, if_a.stage_trig, if_a.apply_trig, if_a.clear_trig, if_a.rd_addr, if_a.rd_shadow} = '0;
    {if_b.din, if_b.addr, if_b.stage_trig, if_b.apply_trig, if_b.clear_trig, if_b.rd_addr, if_b.rd_shadow} = '0;
    {if_c.din, if_c.addr, if_c.stage_trig, if_c.apply_trig, if_c.clear_trig, if_c.rd_addr, if_c.rd_shadow} = '0;
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    tick(); tick(); tick();

    // Reset state (still in reset so readback is held at zero).
    expect_v(64'h00A5_00A5_00A5_00A5); expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h0); expect_v(64'h0);
    check("rst_dout", if_a.dout);
    check("rst_dirty", 64'(if_a.dirty));
    check("rst_cnt", 64'(if_a.apply_cnt));
    check("rst_rd_data", 64'(if_a.rd_data));
    check("rst_applied", 64'(if_a.applied));
    rst_n = 1'b1;
    tick();

    // Stage ch2 with the trigger held 5 cycles; din changes mid-hold must be ignored.
    if_a.addr = 2'd2; if_a.din = 16'h1234; if_a.stage_trig = 1'b1;
    expect_v(64'h4);
    tick();
    check("stage_dirty", 64'(if_a.dirty));
    if_a.din = 16'hFFFF;
    tick(); tick(); tick(); tick();
    expect_v(64'h00A5_00A5_00A5_00A5);
    check("stage_dout_held", if_a.dout);
    if_a.stage_trig = 1'b0;
    if_a.rd_addr = 2'd2; if_a.rd_shadow = 1'b1;
    expect_v(64'h1234);
    tick();
    check("rd_shadow2_held_once", 64'(if_a.rd_data));

    // Apply: dout, one-cycle applied pulse, counter.
    if_a.apply_trig = 1'b1;
    expect_v(64'h00A5_1234_00A5_00A5); expect_v(64'h1); expect_v(64'h1); expect_v(64'h0);
    tick();
    check("apply_dout", if_a.dout);
    check("apply_pulse", 64'(if_a.applied));
    check("apply_cnt1", 64'(if_a.apply_cnt));
    check("apply_dirty", 64'(if_a.dirty));
    expect_v(64'h0); expect_v(64'h1);
    tick();
    check("apply_pulse_end", 64'(if_a.applied));
    check("apply_held_once", 64'(if_a.apply_cnt));
    if_a.apply_trig = 1'b0;

    // Stage ch0 and ch3, then apply + stage ch1 together.
    if_a.addr = 2'd0; if_a.din = 16'h1111; if_a.stage_trig = 1'b1; tick();
    if_a.stage_trig = 1'b0; tick();
    if_a.addr = 2'd3; if_a.din = 16'h3333; if_a.stage_trig = 1'b1;
    expect_v(64'h9);
    tick();
    check("two_dirty", 64'(if_a.dirty));
    if_a.stage_trig = 1'b0; tick();
    if_a.addr = 2'd1; if_a.din = 16'h2222; if_a.stage_trig = 1'b1; if_a.apply_trig = 1'b1;
    expect_v(64'h3333_1234_00A5_1111); expect_v(64'h2); expect_v(64'h2);
    tick();
    check("apply_stage_dout", if_a.dout);
    check("apply_stage_dirty", 64'(if_a.dirty));
    check("apply_stage_cnt", 64'(if_a.apply_cnt));
    if_a.stage_trig = 1'b0; if_a.apply_trig = 1'b0;
    if_a.rd_addr = 2'd1; if_a.rd_shadow = 1'b1;
    tick();
    expect_v(64'h2222);
    check("rd_shadow1", 64'(if_a.rd_data));
    if_a.rd_shadow = 1'b0;
    expect_v(64'h00A5);
    tick();
    check("rd_live1", 64'(if_a.rd_data));

    // NCH=3 bank: out-of-range stage sets sticky addr_err, no bank change.
    if_b.addr = 2'd3; if_b.din = 16'hDEAD; if_b.stage_trig = 1'b1;
    expect_v(64'h1); expect_v(64'h0); expect_v(64'h0055_0055_0055);
    tick();
    check("b_addr_err", 64'(if_b.addr_err));
    check("b_err_dirty", 64'(if_b.dirty));
    check("b_err_dout", if_b.dout);
    if_b.stage_trig = 1'b0; tick();
    if_b.apply_trig = 1'b1;
    expect_v(64'h1); expect_v(64'h0055_0055_0055); expect_v(64'h1);
    tick();
    check("b_err_thru_apply", 64'(if_b.addr_err));
    check("b_apply_dout", if_b.dout);
    check("b_apply_pulse", 64'(if_b.applied));
    if_b.apply_trig = 1'b0;
    if_b.rd_addr = 2'd3; if_b.rd_shadow = 1'b1;
    tick();
    expect_v(64'h0);
    check("b_rd_oob", 64'(if_b.rd_data));
    if_b.addr = 2'd0; if_b.din = 16'h0F0F; if_b.stage_trig = 1'b1; tick();
    if_b.stage_trig = 1'b0; tick();
    if_b.apply_trig = 1'b1;
    expect_v(64'h0055_0055_0F0F); expect_v(64'h2);
    tick();
    check("b_apply2_dout", if_b.dout);
    check("b_apply2_cnt", 64'(if_b.apply_cnt));
    if_b.apply_trig = 1'b0; tick();
    if_b.addr = 2'd1; if_b.din = 16'h7777; if_b.stage_trig = 1'b1; tick();
    if_b.stage_trig = 1'b0; tick();
    // Clear with a simultaneous apply: only the clear acts.
    if_b.clear_trig = 1'b1; if_b.apply_trig = 1'b1;
    expect_v(64'h0055_0055_0055); expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h0); expect_v(64'h2);
    tick();
    check("b_clear_dout", if_b.dout);
    check("b_clear_dirty", 64'(if_b.dirty));
    check("b_clear_err", 64'(if_b.addr_err));
    check("b_clear_no_pulse", 64'(if_b.applied));
    check("b_clear_cnt", 64'(if_b.apply_cnt));
    if_b.clear_trig = 1'b0; if_b.apply_trig = 1'b0;
    if_b.rd_addr = 2'd1; if_b.rd_shadow = 1'b1;
    tick();
    expect_v(64'h0055);
    check("b_clear_shadow", 64'(if_b.rd_data));

    // Auto-apply bank: stage goes live immediately.
    if_c.addr = 2'd1; if_c.din = 16'hBEEF; if_c.stage_trig = 1'b1;
    expect_v(64'h0000_0000_BEEF_0000); expect_v(64'h0); expect_v(64'h1); expect_v(64'h1);
    tick();
    check("c_auto_dout", if_c.dout);
    check("c_auto_dirty", 64'(if_c.dirty));
    check("c_auto_pulse", 64'(if_c.applied));
    check("c_auto_cnt", 64'(if_c.apply_cnt));
    if_c.stage_trig = 1'b0;
    expect_v(64'h0);
    tick();
    check("c_auto_pulse_end", 64'(if_c.applied));

    // Counter wrap: one rising edge per cycle, alternating stage and apply.
    if_c.addr = 2'd2;
    for (int k = 0; k < 65534; k++) begin
      if_c.din        = 16'(k);
      if_c.stage_trig = ~k[0];
      if_c.apply_trig = k[0];
      tick();
    end
    expect_v(64'hFFFF);
    check("c_cnt_ffff", 64'(if_c.apply_cnt));
    if_c.stage_trig = 1'b1; if_c.apply_trig = 1'b0;
    expect_v(64'h0); expect_v(64'h1);
    tick();
    check("c_cnt_wrap", 64'(if_c.apply_cnt));
    check("c_wrap_pulse", 64'(if_c.applied));
    if_c.stage_trig = 1'b0;
    tick();

    // Reset asserted in the middle of a stage.
    if_a.addr = 2'd0; if_a.din = 16'h5555; if_a.stage_trig = 1'b1; if_a.rd_shadow = 1'b1;
    rst_n = 1'b0;
    expect_v(64'h00A5_00A5_00A5_00A5); expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h0); expect_v(64'h0);
    tick();
    check("midrst_dout", if_a.dout);
    check("midrst_dirty", 64'(if_a.dirty));
    check("midrst_cnt", 64'(if_a.apply_cnt));
    check("midrst_rd_data", 64'(if_a.rd_data));
    check("midrst_c_cnt", 64'(if_c.apply_cnt));
    // Trigger still high at reset release acts on the first edge.
    rst_n = 1'b1;
    expect_v(64'h1);
    tick();
    check("post_rst_stage", 64'(if_a.dirty));
    if_a.stage_trig = 1'b0;
    tick();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence needs about 65.7k cycles.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
